// File: rtl/tile_pingpong_skew_buffer_pkg.sv
// Shared types and sizing helpers for the ping-pong skew tile buffer.
// Optional feature macro: TILE_BUF_TRANSPOSE_EN (used by the lane mux).
package tile_buf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    // A skewed drain of an n x n tile takes 2n-1 beats.
    function automatic int skew_steps(input int n);
        return 2 * n - 1;
    endfunction

    // Width of the per-bank write row counter.
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

    // Width of the skew step counter.
    function automatic int step_w(input int n);
        return $clog2(skew_steps(n));
    endfunction

endpackage

// File: rtl/tile_pingpong_skew_buffer_if.sv
// Loader-side write handshake plus array-side skewed read stream.
// master = loader/array side, slave = the tile buffer.
interface tile_buf_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 3
);
    logic                              wr_valid;
    logic                              wr_ready;
    logic [DATA_WIDTH*MATRIX_SIZE-1:0] wr_data_flat;
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_WIDTH*MATRIX_SIZE-1:0] out_data_flat;
    logic [MATRIX_SIZE-1:0]            out_lane_valid;
    logic                              out_last;
    logic [1:0]                        full_flags;

    modport master (
        output wr_valid, wr_data_flat, out_ready,
        input  wr_ready, out_valid, out_data_flat, out_lane_valid, out_last, full_flags
    );

    modport slave (
        input  wr_valid, wr_data_flat, out_ready,
        output wr_ready, out_valid, out_data_flat, out_lane_valid, out_last, full_flags
    );
endinterface

// File: rtl/tile_pingpong_skew_buffer_skew_lane_mux.sv
// One output lane of the skewed feed: picks the tile element for this lane at
// the current step and flags whether the lane is inside the diagonal window.
// With TILE_BUF_TRANSPOSE_EN defined the row/column roles are swapped so the
// same loader can feed the column edge of the array.
module skew_lane_mux
    import tile_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int LANE        = 0
) (
    input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] tile,
    input  logic [step_w(MATRIX_SIZE)-1:0]                          step,
    output logic [DATA_WIDTH-1:0]                                   data,
    output logic                                                    lane_valid
);
    localparam int N  = MATRIX_SIZE;
    localparam int SW = step_w(N);
    localparam int RW = cnt_w(N);

    logic [SW-1:0] rel;
    logic [RW-1:0] rel_idx;
    logic [RW-1:0] lane_idx;
    logic [RW-1:0] row;
    logic [RW-1:0] col;

    assign lane_idx = RW'(LANE);

    // Diagonal window test and element select; idle lanes drive zero.
    always_comb begin
        rel        = step - SW'(LANE);
        rel_idx    = rel[RW-1:0];
        lane_valid = (step >= SW'(LANE)) && (rel < SW'(N));
`ifdef TILE_BUF_TRANSPOSE_EN
        row = lane_idx;
        col = rel_idx;
`else
        row = rel_idx;
        col = lane_idx;
`endif
        data = '0;
        if (lane_valid) data = tile[row][col];
    end
endmodule

// File: rtl/tile_pingpong_skew_buffer.sv
// Two-bank ping-pong tile buffer: writer fills one bank a row per beat while
// the reader drains the other as a diagonally skewed systolic feed.
// Bank swaps follow the handshakes; a full next bank drains with no bubble.
// Optional feature macro: TILE_BUF_TRANSPOSE_EN (transposed read mapping).
module tile_pingpong_skew_buffer
    import tile_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic      clk,
    input  logic      rst,
    tile_buf_if.slave bus
);
    localparam int N         = MATRIX_SIZE;
    localparam int CW        = cnt_w(N);
    localparam int SW        = step_w(N);
    localparam int LAST_STEP = skew_steps(N) - 1;

    typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] tile_t;

    tile_t [1:0]                  bank;
    logic                         wr_sel, rd_sel;
    logic [1:0]                   full, full_nxt;
    logic [CW-1:0]                wr_cnt;
    logic [SW-1:0]                rd_step;
    rd_state_t                    state, state_nxt;
    logic                         wr_rdy, wr_acc, wr_last;
    logic                         drain, rd_acc, rd_last;
    logic [N-1:0][DATA_WIDTH-1:0] lane_data;
    logic [N-1:0]                 lane_vld;

    assign wr_rdy  = !full[wr_sel];
    assign wr_acc  = bus.wr_valid && wr_rdy;
    assign wr_last = (wr_cnt == CW'(N - 1));
    assign drain   = (state == DRAIN);
    assign rd_acc  = drain && bus.out_ready;
    assign rd_last = (rd_step == SW'(LAST_STEP));

    // Next full flags: completing a write and releasing a read hit different banks.
    always_comb begin
        full_nxt = full;
        if (wr_acc && wr_last) full_nxt[wr_sel] = 1'b1;
        if (rd_acc && rd_last) full_nxt[rd_sel] = 1'b0;
    end

    // Reader state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Reader next state; look at the post-update flag of the other bank so a
    // tile completing on the release edge still streams without a bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rd_sel]) state_nxt = DRAIN;
            DRAIN:   if (rd_acc && rd_last) state_nxt = full_nxt[~rd_sel] ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reader outputs; everything is masked off outside DRAIN.
    always_comb begin
        bus.out_valid      = drain;
        bus.out_last       = drain && rd_last;
        bus.out_lane_valid = drain ? lane_vld : '0;
        bus.out_data_flat  = drain ? lane_data : '0;
        bus.wr_ready       = wr_rdy;
        bus.full_flags     = full;
    end

    // Bank storage, write pointer, read pointer and bank flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank    <= '0;
            wr_sel  <= 1'b0;
            wr_cnt  <= '0;
            rd_sel  <= 1'b0;
            rd_step <= '0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_acc) begin
                bank[wr_sel][wr_cnt] <= bus.wr_data_flat;
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
                if (wr_last) wr_sel <= ~wr_sel;
            end
            if (rd_acc) begin
                rd_step <= rd_last ? '0 : rd_step + 1'b1;
                if (rd_last) rd_sel <= ~rd_sel;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_lane_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .MATRIX_SIZE(MATRIX_SIZE),
            .LANE       (g)
        ) u_lane (
            .tile      (bank[rd_sel]),
            .step      (rd_step),
            .data      (lane_data[g]),
            .lane_valid(lane_vld[g])
        );
    end
endmodule
